// File: rtl/pet_needs_pkg.sv
// Shared definitions for the virtual-pet needs tracker: stat width, mood codes, mood helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pet_needs_pkg;

    localparam int STAT_W  = 3;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_NORMAL = 3'd0,
        ST_SAD    = 3'd1,
        ST_TIRED  = 3'd2,
        ST_HUNGRY = 3'd3,
        ST_SLEEP  = 3'd4,
        ST_DEAD   = 3'd5
    } pet_state_t;

    // Mood of an awake pet; the most urgent need wins.
    function automatic pet_state_t awake_state(
        input logic [STAT_W-1:0] h,
        input logic [STAT_W-1:0] e,
        input logic [STAT_W-1:0] p
    );
        if (h <= STAT_W'(1))      return ST_HUNGRY;
        else if (e <= STAT_W'(1)) return ST_TIRED;
        else if (p <= STAT_W'(1)) return ST_SAD;
        else                      return ST_NORMAL;
    endfunction

endpackage

// File: rtl/pet_needs_stat_counter.sv
// One pet stat: tick period counter plus a saturating value with add/sub/inc controls.
// Latency: one cycle from any control input to the registered stat.
// Backpressure: none; every control is acted on in the cycle it is presented.
//
// Ports: clk, reset (sync, active-high); decay_tick advances the period counter and
// decrements the stat on wrap; add_gain adds GAIN and clears the counter (decay dropped);
// sub_one / inc_one nudge the stat by one; stat is the saturated value 0..STAT_MAX.
module stat_counter
    import pet_needs_pkg::*;
#(
    parameter int PERIOD   = 6,
    parameter int STAT_MAX = 5,
    parameter int GAIN     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              decay_tick,
    input  logic              add_gain,
    input  logic              sub_one,
    input  logic              inc_one,
    output logic [STAT_W-1:0] stat
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int SUM_W = STAT_W + 2;

    logic [CNT_W-1:0] cnt;
    logic             wrap;
    logic [SUM_W-1:0] up;
    logic [SUM_W-1:0] down;
    logic [SUM_W-1:0] raw_next;
    logic [STAT_W-1:0] stat_next;

    assign wrap = decay_tick && (cnt == CNT_W'(PERIOD - 1));

    // Work in a wider unsigned domain so both saturation ends are simple compares.
    always_comb begin
        up   = SUM_W'(stat) + SUM_W'(inc_one);
        down = SUM_W'(wrap) + SUM_W'(sub_one);
        if (add_gain) begin
            // The add wins over a coincident wrap; the decay is simply dropped.
            raw_next = SUM_W'(stat) + SUM_W'(GAIN);
        end else if (up > down) begin
            raw_next = up - down;
        end else begin
            raw_next = '0;
        end
        stat_next = (raw_next > SUM_W'(STAT_MAX)) ? STAT_W'(STAT_MAX) : raw_next[STAT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat <= STAT_W'(STAT_MAX);
            cnt  <= '0;
        end else begin
            stat <= stat_next;
            if (add_gain) begin
                cnt <= '0;
            end else if (decay_tick) begin
                cnt <= wrap ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pet_needs.sv
// Virtual-pet needs tracker: three decaying stats, button commands and a mood FSM.
// Latency: tick is combinational from secondpassed; stats and mood register one cycle later.
// Backpressure: none; buttons arriving while asleep or dead are dropped.
//
// Ports: clk, reset (sync, active-high); secondpassed timebase (each edge is a tick);
// btn_feed/btn_sleep/btn_play one-cycle commands; hunger/energy/happiness stats;
// pet_state mood code (pet_state_t); tick one-cycle pulse per detected timebase edge.
module pet_needs
    import pet_needs_pkg::*;
#(
    parameter int STAT_MAX      = 5,
    parameter int HUNGER_PERIOD = 6,
    parameter int ENERGY_PERIOD = 8,
    parameter int HAPPY_PERIOD  = 5,
    parameter int GAIN          = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               secondpassed,
    input  logic               btn_feed,
    input  logic               btn_sleep,
    input  logic               btn_play,
    output logic [STAT_W-1:0]  hunger,
    output logic [STAT_W-1:0]  energy,
    output logic [STAT_W-1:0]  happiness,
    output logic [STATE_W-1:0] pet_state,
    output logic               tick
);

    logic       sp_q;
    pet_state_t state;
    pet_state_t state_next;
    logic       frozen;
    logic       sleeping;
    logic       feed_go;
    logic       play_go;

    // sp_q follows the input in reset too, so releasing reset never produces a false tick.
    always_ff @(posedge clk) begin
        sp_q <= secondpassed;
    end

    assign tick = (secondpassed ^ sp_q) & ~reset;

    // Both hunger and energy empty freezes the stats in the same cycle, a cycle before
    // the mood register shows DEAD, so nothing can revive the pet in between.
    assign frozen   = (state == ST_DEAD) || ((hunger == '0) && (energy == '0));
    assign sleeping = (state == ST_SLEEP);
    assign feed_go  = btn_feed & ~btn_sleep & ~sleeping & ~frozen;
    assign play_go  = btn_play & ~btn_feed & ~btn_sleep & ~sleeping & ~frozen & (energy != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_NORMAL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (frozen) begin
            state_next = ST_DEAD;
        end else if (state == ST_SLEEP) begin
            if (energy == STAT_W'(STAT_MAX)) begin
                state_next = awake_state(hunger, energy, happiness);
            end
        end else if (btn_sleep) begin
            state_next = ST_SLEEP;
        end else begin
            state_next = awake_state(hunger, energy, happiness);
        end
    end

    assign pet_state = state;

    stat_counter #(
        .PERIOD   (HUNGER_PERIOD),
        .STAT_MAX (STAT_MAX),
        .GAIN     (GAIN)
    ) u_hunger (
        .clk        (clk),
        .reset      (reset),
        .decay_tick (tick & ~frozen),
        .add_gain   (feed_go),
        .sub_one    (1'b0),
        .inc_one    (1'b0),
        .stat       (hunger)
    );

    stat_counter #(
        .PERIOD   (HAPPY_PERIOD),
        .STAT_MAX (STAT_MAX),
        .GAIN     (GAIN)
    ) u_happiness (
        .clk        (clk),
        .reset      (reset),
        .decay_tick (tick & ~frozen),
        .add_gain   (play_go),
        .sub_one    (1'b0),
        .inc_one    (1'b0),
        .stat       (happiness)
    );

    // While asleep the energy period counter holds and each tick recharges instead.
    stat_counter #(
        .PERIOD   (ENERGY_PERIOD),
        .STAT_MAX (STAT_MAX),
        .GAIN     (GAIN)
    ) u_energy (
        .clk        (clk),
        .reset      (reset),
        .decay_tick (tick & ~frozen & ~sleeping),
        .add_gain   (1'b0),
        .sub_one    (play_go),
        .inc_one    (tick & sleeping & ~frozen),
        .stat       (energy)
    );

endmodule

// File: tb/tb_pet_needs.sv
module tb_pet_needs;

    localparam int MAXV = 5;
    localparam int HP   = 6;
    localparam int EP   = 8;
    localparam int PP   = 5;
    localparam int G    = 2;

    localparam int S_NORMAL = 0;
    localparam int S_SAD    = 1;
    localparam int S_TIRED  = 2;
    localparam int S_HUNGRY = 3;
    localparam int S_SLEEP  = 4;
    localparam int S_DEAD   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       secondpassed = 1'b0;
    logic       btn_feed = 1'b0;
    logic       btn_sleep = 1'b0;
    logic       btn_play = 1'b0;
    logic [2:0] hunger;
    logic [2:0] energy;
    logic [2:0] happiness;
    logic [2:0] pet_state;
    logic       tick;

    int checks = 0;
    int errors = 0;

    pet_needs #(
        .STAT_MAX      (MAXV),
        .HUNGER_PERIOD (HP),
        .ENERGY_PERIOD (EP),
        .HAPPY_PERIOD  (PP),
        .GAIN          (G)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .secondpassed (secondpassed),
        .btn_feed     (btn_feed),
        .btn_sleep    (btn_sleep),
        .btn_play     (btn_play),
        .hunger       (hunger),
        .energy       (energy),
        .happiness    (happiness),
        .pet_state    (pet_state),
        .tick         (tick)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_h, m_e, m_p;       // stats
    int m_hc, m_ec, m_pc;    // ticks seen since last decrement
    int m_st;                // mood
    bit m_spq;               // last sampled timebase level
    bit m_valid = 1'b0;

    function automatic int mood(input int h, input int e, input int p);
        if (h <= 1) return S_HUNGRY;
        if (e <= 1) return S_TIRED;
        if (p <= 1) return S_SAD;
        return S_NORMAL;
    endfunction

    always @(posedge clk) begin : model
        bit t, frz, slp, fd, pl;
        int nst, dec;
        if (reset) begin
            m_h = MAXV; m_e = MAXV; m_p = MAXV;
            m_hc = 0; m_ec = 0; m_pc = 0;
            m_st = S_NORMAL;
            m_spq = secondpassed;
            m_valid = 1'b1;
        end else begin
            t     = (secondpassed != m_spq);
            m_spq = secondpassed;
            frz   = (m_st == S_DEAD) || (m_h == 0 && m_e == 0);
            slp   = (m_st == S_SLEEP);
            if (frz)            nst = S_DEAD;
            else if (slp)       nst = (m_e == MAXV) ? mood(m_h, m_e, m_p) : S_SLEEP;
            else if (btn_sleep) nst = S_SLEEP;
            else                nst = mood(m_h, m_e, m_p);
            if (!frz) begin
                fd = btn_feed && !btn_sleep && !slp;
                pl = btn_play && !btn_feed && !btn_sleep && !slp && (m_e > 0);
                if (fd) begin
                    m_h = (m_h + G > MAXV) ? MAXV : m_h + G;
                    m_hc = 0;
                end else if (t) begin
                    m_hc++;
                    if (m_hc == HP) begin m_hc = 0; if (m_h > 0) m_h--; end
                end
                if (pl) begin
                    m_p = (m_p + G > MAXV) ? MAXV : m_p + G;
                    m_pc = 0;
                end else if (t) begin
                    m_pc++;
                    if (m_pc == PP) begin m_pc = 0; if (m_p > 0) m_p--; end
                end
                dec = pl ? 1 : 0;
                if (t && !slp) begin
                    m_ec++;
                    if (m_ec == EP) begin m_ec = 0; dec++; end
                end
                if (t && slp && m_e < MAXV) m_e++;
                m_e = (m_e > dec) ? m_e - dec : 0;
            end
            m_st = nst;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [7:0] act, input int exp);
        checks++;
        if (act !== 8'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("hunger", {5'd0, hunger}, m_h);
        chk("energy", {5'd0, energy}, m_e);
        chk("happiness", {5'd0, happiness}, m_p);
        chk("pet_state", {5'd0, pet_state}, m_st);
        chk("tick", {7'd0, tick}, ((secondpassed != m_spq) && !reset) ? 1 : 0);
    endtask

    // Compare on the falling edge, then return just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        if (m_valid) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle();
        secondpassed = ~secondpassed;
        cyc();
    endtask

    task automatic press(input int which);
        btn_feed  = (which == 0);
        btn_sleep = (which == 1);
        btn_play  = (which == 2);
        cyc();
        btn_feed = 1'b0; btn_sleep = 1'b0; btn_play = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst_hunger", {5'd0, hunger}, 5);
        chk("rst_energy", {5'd0, energy}, 5);
        chk("rst_happiness", {5'd0, happiness}, 5);
        chk("rst_state", {5'd0, pet_state}, S_NORMAL);
        #1 chk("rst_tick", {7'd0, tick}, 0);

        // Six ticks, no buttons.
        for (int i = 1; i <= 6; i++) begin
            toggle();
            if (i == 5) begin
                chk("decay5_happiness", {5'd0, happiness}, 4);
                chk("decay5_hunger", {5'd0, hunger}, 5);
            end
            if (i == 6) begin
                chk("decay6_hunger", {5'd0, hunger}, 4);
                chk("decay6_energy", {5'd0, energy}, 5);
            end
            cyc();
        end

        // Feed coincident with the 6th hunger tick: add wins, decay dropped, counter cleared.
        for (int i = 0; i < 5; i++) toggle();
        btn_feed = 1'b1;
        secondpassed = ~secondpassed;
        cyc();
        btn_feed = 1'b0;
        chk("feed_tick_hunger", {5'd0, hunger}, 5);
        for (int i = 0; i < 5; i++) toggle();
        chk("feed_cnt_clear_hunger", {5'd0, hunger}, 5);
        toggle();
        chk("feed_cnt_wrap_hunger", {5'd0, hunger}, 4);

        // Sleep recharge from energy 2.
        do_reset();
        for (int i = 0; i < 3; i++) press(2);
        chk("play3_energy", {5'd0, energy}, 2);
        chk("play3_happiness", {5'd0, happiness}, 5);
        press(1);
        chk("sleep_enter", {5'd0, pet_state}, S_SLEEP);
        press(0);
        chk("sleep_feed_ignored_hunger", {5'd0, hunger}, 5);
        for (int i = 0; i < 3; i++) toggle();
        chk("sleep_energy_full", {5'd0, energy}, 5);
        cyc();
        chk("sleep_exit_state", {5'd0, pet_state}, S_NORMAL);

        // Reset in the middle of sleep.
        press(2);
        press(1);
        chk("sleep2_enter", {5'd0, pet_state}, S_SLEEP);
        do_reset();
        chk("sleep_reset_state", {5'd0, pet_state}, S_NORMAL);
        chk("sleep_reset_energy", {5'd0, energy}, 5);

        // Play with no energy left does nothing.
        for (int i = 0; i < 5; i++) press(2);
        chk("play5_energy", {5'd0, energy}, 0);
        for (int i = 0; i < 10; i++) toggle();
        press(2);
        chk("play_empty_happiness", {5'd0, happiness}, 3);
        chk("play_empty_energy", {5'd0, energy}, 0);
        chk("play_empty_state", {5'd0, pet_state}, S_TIRED);

        // Starve to death.
        for (int i = 0; i < 60 && pet_state != 3'(S_DEAD); i++) toggle();
        chk("dead_state", {5'd0, pet_state}, S_DEAD);
        chk("dead_hunger", {5'd0, hunger}, 0);
        chk("dead_energy", {5'd0, energy}, 0);
        btn_feed = 1'b1; btn_play = 1'b1; btn_sleep = 1'b1;
        secondpassed = ~secondpassed;
        #1 chk("dead_tick", {7'd0, tick}, 1);
        cyc();
        btn_feed = 1'b0; btn_play = 1'b0; btn_sleep = 1'b0;
        press(0);
        for (int i = 0; i < 8; i++) toggle();
        chk("dead_frozen_hunger", {5'd0, hunger}, 0);
        chk("dead_frozen_state", {5'd0, pet_state}, S_DEAD);
        do_reset();
        chk("dead_reset_state", {5'd0, pet_state}, S_NORMAL);
        chk("dead_reset_hunger", {5'd0, hunger}, 5);
        chk("dead_reset_happiness", {5'd0, happiness}, 5);

        // Reset while the timebase is high: no tick after release.
        reset = 1'b1;
        secondpassed = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        #1 chk("release_no_tick", {7'd0, tick}, 0);
        cyc();
        chk("release_hunger", {5'd0, hunger}, 5);

        // Randomised run against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 30) secondpassed = ~secondpassed;
            btn_feed  = ($urandom_range(0, 9) == 0);
            btn_sleep = ($urandom_range(0, 11) == 0);
            btn_play  = ($urandom_range(0, 7) == 0);
            reset     = ($urandom_range(0, 599) == 0);
            cyc();
        end
        btn_feed = 1'b0; btn_sleep = 1'b0; btn_play = 1'b0; reset = 1'b0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
